// File: rtl/fp9_multiplier.sv
// +----------------------------------------------------------------------+
// | fp9_multiplier: 3-stage valid/ready pipelined multiplier for the     |
// | 9-bit float format (1 sign, 4 exponent, 4 fraction, bias 7).         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fp9_multiplier #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 4,
  parameter int BIAS   = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   A,
  input  logic [EXP_W+FRAC_W:0]   B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out,
  output logic                    out_ovf,
  output logic                    out_unf
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int MW  = FRAC_W + 1;
  localparam int PW  = 2 * MW;
  localparam int EW  = EXP_W + 3;
  localparam int FW1 = FRAC_W + 1;

  localparam logic signed [EW-1:0] C_E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] C_E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] C_E_BIAS = EW'(BIAS);

  logic                  advance;

  logic                  v1_q, s1_q, z1_q;
  logic signed [EW-1:0]  e1_q, e1_d;
  logic [MW-1:0]         ma1_q, mb1_q;

  logic                  v2_q, s2_q, z2_q;
  logic signed [EW-1:0]  e2_q;
  logic [PW-1:0]         p2_q, p2_d;

  logic                  vo_q, ovf_q, unf_q, ovf_d, unf_d;
  logic [W-1:0]          out_q, out_d;

  logic [FRAC_W-1:0]     frac_n, frac_o;
  logic [FW1-1:0]        frac_r;
  logic                  guard, sticky;
  logic signed [EW-1:0]  e_n, e_r;

  assign advance   = !vo_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = vo_q;
  assign out       = out_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

  // Exponent sum kept signed and wide enough for underflow and double increment
  assign e1_d = signed'(EW'(A[W-2:FRAC_W]) + EW'(B[W-2:FRAC_W])) - C_E_BIAS;
  assign p2_d = PW'(ma1_q) * PW'(mb1_q);

  always_comb begin
    if (p2_q[PW-1]) begin
      frac_n = p2_q[PW-2 -: FRAC_W];
      guard  = p2_q[PW-2-FRAC_W];
      sticky = |p2_q[PW-3-FRAC_W:0];
      e_n    = e2_q + C_E_ONE;
    end else begin
      frac_n = p2_q[PW-3 -: FRAC_W];
      guard  = p2_q[PW-3-FRAC_W];
      sticky = |p2_q[PW-4-FRAC_W:0];
      e_n    = e2_q;
    end
    frac_r = {1'b0, frac_n} + FW1'(guard && (sticky || frac_n[0]));
    frac_o = frac_r[FRAC_W-1:0];
    e_r    = frac_r[FRAC_W] ? e_n + C_E_ONE : e_n;

    out_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (!z2_q) begin
      if (e_r > C_E_MAX) begin
        out_d = {s2_q, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
        ovf_d = 1'b1;
      end else if (e_r < C_E_ONE) begin
        unf_d = 1'b1;
      end else begin
        out_d = {s2_q, e_r[EXP_W-1:0], frac_o};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      s1_q  <= 1'b0;
      z1_q  <= 1'b0;
      e1_q  <= '0;
      ma1_q <= '0;
      mb1_q <= '0;
      v2_q  <= 1'b0;
      s2_q  <= 1'b0;
      z2_q  <= 1'b0;
      e2_q  <= '0;
      p2_q  <= '0;
      vo_q  <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (advance) begin
      v1_q  <= in_valid;
      s1_q  <= A[W-1] ^ B[W-1];
      z1_q  <= (A[W-2:FRAC_W] == '0) || (B[W-2:FRAC_W] == '0);
      e1_q  <= e1_d;
      ma1_q <= {1'b1, A[FRAC_W-1:0]};
      mb1_q <= {1'b1, B[FRAC_W-1:0]};
      v2_q  <= v1_q;
      s2_q  <= s1_q;
      z2_q  <= z1_q;
      e2_q  <= e1_q;
      p2_q  <= p2_d;
      vo_q  <= v2_q;
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp9_multiplier.sv
// +----------------------------------------------------------------------+
// | tb_fp9_multiplier: scoreboard bench for fp9_multiplier with a        |
// | value-level reference multiply and random backpressure.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fp9_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_unf;
  logic [8:0]  A, B, out;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [10:0] cur_exp;
  bit          steady;
  bit          rand_bp;
  bit          hold_v;
  logic [10:0] held;

  typedef struct {
    logic [10:0] exp;
    int          t;
    bit          lat;
  } item_t;
  item_t sb[$];

  fp9_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Value-level reference: exact integer significand product, then
  // round-half-even to 5 significant bits and range-check the exponent.
  function automatic logic [10:0] ref_mul(input logic [8:0] a, input logic [8:0] b);
    int ea, eb, m, e, k, q, r, half;
    bit s;
    ea = int'(a[7:4]);
    eb = int'(b[7:4]);
    s  = a[8] ^ b[8];
    if (ea == 0 || eb == 0) return 11'h000;
    m = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
    e = ea + eb - 7;
    k = (m >= 512) ? 5 : 4;
    e = e + (k - 4);
    q = m / (1 << k);
    r = m % (1 << k);
    half = 1 << (k - 1);
    if (r > half || (r == half && (q % 2) == 1)) q++;
    if (q == 32) begin
      q = 16;
      e++;
    end
    if (e > 15) return {2'b10, s, 8'hFF};
    if (e < 1)  return 11'h200;
    return {2'b00, s, 4'(e), 4'(q - 16)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      check_eq("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (hold_v)
        check_eq("hold", {20'b0, out_valid, out_ovf, out_unf, out}, {20'b0, 1'b1, held});
      hold_v = out_valid && !out_ready;
      held   = {out_ovf, out_unf, out};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          item_t it;
          it = sb.pop_front();
          check_eq("product", {21'b0, out_ovf, out_unf, out}, {21'b0, it.exp});
          if (it.lat) check_eq("latency", cyc - it.t, 32'd3);
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, cyc, steady});
    end
  end

  task automatic send(input logic [8:0] a, input logic [8:0] b, input logic [10:0] e);
    int  n;
    bit  xfer;
    n        = 0;
    A        = a;
    B        = b;
    cur_exp  = e;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      xfer = in_ready;
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      if (xfer) break;
      n++;
      if (n > 200) begin
        check_eq("send_timeout", n, 32'd0);
        break;
      end
    end
  endtask

  task automatic send_rand();
    logic [8:0] a, b;
    a = 9'($urandom);
    b = 9'($urandom);
    send(a, b, ref_mul(a, b));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", sb.size(), 32'd0);
  endtask

  logic [8:0]  dir_a [10] = '{9'h078, 9'h170, 9'h000, 9'h00A, 9'h07B,
                              9'h073, 9'h075, 9'h0FF, 9'h010, 9'h1FF};
  logic [8:0]  dir_b [10] = '{9'h078, 9'h078, 9'h17F, 9'h070, 9'h078,
                              9'h078, 9'h078, 9'h0FF, 9'h110, 9'h0FF};
  // {ovf, unf, out}; 1.6875 x 1.5 = 2.53125 rounds to 2.5 = 9'h084
  logic [10:0] dir_e [10] = '{11'h082, 11'h178, 11'h000, 11'h000, 11'h084,
                              11'h07C, 11'h080, 11'h4FF, 11'h200, 11'h5FF};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    cur_exp   = '0;
    steady    = 1'b1;
    rand_bp   = 1'b0;
    hold_v    = 1'b0;
    held      = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out", {21'b0, out_ovf, out_unf, out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed values back to back with out_ready held high
    for (int i = 0; i < 10; i++) send(dir_a[i], dir_b[i], dir_e[i]);
    drain();

    // Stall with the pipe full, then release
    steady    = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("stall_out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands, gaps and backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_rand();
    end
    drain();

    // Reset with products in flight
    steady = 1'b1;
    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("async_rst_out", {23'b0, out}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(6);
    check_eq("post_rst_empty", sb.size(), 32'd0);
    send(9'h078, 9'h078, 11'h082);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
